// File: rtl/pb_filter_pkg.sv
// pb_filter_pkg: shared constants and per-channel state bundle
// for the push-button conditioning block.
package pb_filter_pkg;

  localparam int PB_STABLE_CYC_DEF = 500000;
  localparam int PB_HOLD_CYC_DEF   = 50000000;

  // Fields are wide enough for any legal parameter set; each
  // channel only ever loads the low bits it needs, so the upper
  // flops are constant zero and drop out in synthesis.
  localparam int PB_CNT_W  = 32;
  localparam int PB_HCNT_W = 32;

  typedef struct packed {
    logic                 fltrd;
    logic [PB_CNT_W-1:0]  cnt;
    logic [PB_HCNT_W-1:0] hcnt;
  } pb_ch_state_t;

endpackage

// File: rtl/pb_filter_ch.sv
// pb_filter_ch: one button channel - synchroniser, debounce
// window, press/release pulses and long-press hold flag.
module pb_filter_ch
  import pb_filter_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CYC  = PB_STABLE_CYC_DEF,
  parameter int HOLD_CYC    = PB_HOLD_CYC_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pb_n,
  input  logic inhibit_press,
  output logic want_press,
  output logic o_fltrd,
  output logic o_press_p,
  output logic o_release_p,
  output logic o_hold
);

  localparam int CW = $clog2(STABLE_CYC);
  localparam int HW = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;
  localparam logic [PB_CNT_W-1:0] CNT_TOP =
    PB_CNT_W'(STABLE_CYC - 1);
  localparam logic [PB_HCNT_W-1:0] HCNT_TOP =
    PB_HCNT_W'(HOLD_CYC);
  localparam logic HOLD_EN = (HOLD_CYC > 0);

  logic [SYNC_STAGES-1:0] r_sync;
  pb_ch_state_t           r_st;
  pb_ch_state_t           w_nxt;
  logic                   r_press_p;
  logic                   r_release_p;
  logic                   r_hold;

  logic          w_s;
  logic          w_differ;
  logic          w_at_top;
  logic          w_toggle;
  logic          w_hold_nxt;
  logic [CW-1:0] w_cnt_inc;
  logic [HW-1:0] w_hcnt_inc;

  assign w_s       = r_sync[SYNC_STAGES-1];
  assign w_differ  = (w_s != r_st.fltrd);
  assign w_at_top  = (r_st.cnt == CNT_TOP);
  assign w_cnt_inc = r_st.cnt[CW-1:0] + CW'(1);
  assign w_hcnt_inc = r_st.hcnt[HW-1:0] + HW'(1);

  // A press candidate is reported even when inhibited so the top
  // level can resolve priority between simultaneous presses.
  assign want_press = w_differ & r_st.fltrd & w_at_top;
  assign w_toggle   = w_differ & w_at_top &
                      ~(r_st.fltrd & inhibit_press);

  // Shift the raw active-low pin through the synchroniser chain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pb_n};
    end
  end

  // Next-state for debounce window, filtered level and hold age.
  always_comb begin
    w_nxt = r_st;
    if (!w_differ) begin
      w_nxt.cnt = '0;
    end else if (!w_at_top) begin
      w_nxt.cnt = PB_CNT_W'(w_cnt_inc);
    end else if (w_toggle) begin
      w_nxt.fltrd = ~r_st.fltrd;
      w_nxt.cnt   = '0;
    end
    if (r_st.fltrd) begin
      w_nxt.hcnt = '0;
    end else if (r_st.hcnt != HCNT_TOP) begin
      w_nxt.hcnt = PB_HCNT_W'(w_hcnt_inc);
    end
    w_hold_nxt = HOLD_EN & ~w_nxt.fltrd &
                 (r_st.hcnt == HCNT_TOP);
  end

  // Register channel state and the pulse/hold outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_st.fltrd  <= 1'b1;
      r_st.cnt    <= '0;
      r_st.hcnt   <= '0;
      r_press_p   <= 1'b0;
      r_release_p <= 1'b0;
      r_hold      <= 1'b0;
    end else begin
      r_st        <= w_nxt;
      r_press_p   <= w_toggle & r_st.fltrd;
      r_release_p <= w_toggle & ~r_st.fltrd;
      r_hold      <= w_hold_nxt;
    end
  end

  assign o_fltrd     = r_st.fltrd;
  assign o_press_p   = r_press_p;
  assign o_release_p = r_release_p;
  assign o_hold      = r_hold;

endmodule

// File: rtl/pb_filter_n.sv
// pb_filter_n: N-channel push-button conditioner with optional
// cross-talk lockout (one accepted press at a time).
module pb_filter_n
  import pb_filter_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CYC  = PB_STABLE_CYC_DEF,
  parameter int HOLD_CYC    = PB_HOLD_CYC_DEF,
  parameter int LOCKOUT     = 1
) (
  input  logic            clkin_50,
  input  logic            rst_n,
  input  logic [N_CH-1:0] pb_n,
  output logic [N_CH-1:0] pb_n_fltrd,
  output logic [N_CH-1:0] press_p,
  output logic [N_CH-1:0] release_p,
  output logic [N_CH-1:0] hold
);

  logic [N_CH-1:0] w_want;
  logic [N_CH-1:0] w_inhibit;

  // Block a press while another button is down or a lower index
  // wants to press in the same cycle.
  always_comb begin
    w_inhibit = '0;
    if (LOCKOUT != 0) begin
      for (int i = 0; i < N_CH; i++) begin
        for (int j = 0; j < N_CH; j++) begin
          if ((j != i) && !pb_n_fltrd[j]) w_inhibit[i] = 1'b1;
          if ((j < i) && w_want[j])        w_inhibit[i] = 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    pb_filter_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .STABLE_CYC  (STABLE_CYC),
      .HOLD_CYC    (HOLD_CYC)
    ) u_ch (
      .i_clk         (clkin_50),
      .i_rst_n       (rst_n),
      .i_pb_n        (pb_n[g]),
      .inhibit_press (w_inhibit[g]),
      .want_press    (w_want[g]),
      .o_fltrd       (pb_n_fltrd[g]),
      .o_press_p     (press_p[g]),
      .o_release_p   (release_p[g]),
      .o_hold        (hold[g])
    );
  end

endmodule

// File: tb/tb_pb_filter_n.sv
// tb_pb_filter_n: directed, table-driven and random checks of
// pb_filter_n against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_pb_filter_n;

  localparam int NC = 4;
  localparam int SS = 2;
  localparam int ST = 8;
  localparam int HC = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NC-1:0] pb_n = '0;
  logic [NC-1:0] fltrd, press, rel, hold;
  logic [NC-1:0] fltrd0, press0, rel0, hold0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pb_filter_n #(
    .N_CH(NC), .SYNC_STAGES(SS), .STABLE_CYC(ST),
    .HOLD_CYC(HC), .LOCKOUT(1)
  ) u_dut (
    .clkin_50(clk), .rst_n(rst_n), .pb_n(pb_n),
    .pb_n_fltrd(fltrd), .press_p(press),
    .release_p(rel), .hold(hold)
  );

  pb_filter_n #(
    .N_CH(NC), .SYNC_STAGES(SS), .STABLE_CYC(ST),
    .HOLD_CYC(HC), .LOCKOUT(0)
  ) u_dut0 (
    .clkin_50(clk), .rst_n(rst_n), .pb_n(pb_n),
    .pb_n_fltrd(fltrd0), .press_p(press0),
    .release_p(rel0), .hold(hold0)
  );

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- behavioural model (LOCKOUT=1) -------------
  // Each button: count consecutive synchronised samples that
  // disagree with the accepted level; accept after ST of them.
  // Presses need every other button up and no lower candidate.
  logic [NC-1:0] m_pipe [SS];
  int            m_run [NC];
  int            m_age [NC];
  logic [NC-1:0] m_f, m_pr, m_rl, m_hd;
  bit            m_en = 1'b0;

  task automatic model_reset();
    for (int k = 0; k < SS; k++) m_pipe[k] = '1;
    for (int c = 0; c < NC; c++) begin
      m_run[c] = 0;
      m_age[c] = 0;
    end
    m_f = '1; m_pr = '0; m_rl = '0; m_hd = '0;
  endtask

  task automatic model_step();
    logic [NC-1:0] s, nf;
    bit taken;
    s = m_pipe[SS-1];
    for (int k = SS - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
    m_pipe[0] = pb_n;
    nf = m_f; m_pr = '0; m_rl = '0; taken = 1'b0;
    for (int c = 0; c < NC; c++) begin
      m_run[c] = (s[c] != m_f[c]) ? m_run[c] + 1 : 0;
      if (m_run[c] >= ST) begin
        if (!m_f[c]) begin
          nf[c] = 1'b1; m_rl[c] = 1'b1; m_run[c] = 0;
        end else begin
          logic [NC-1:0] others;
          others = ~m_f;
          others[c] = 1'b0;
          if (others == '0 && !taken) begin
            nf[c] = 1'b0; m_pr[c] = 1'b1; m_run[c] = 0;
          end
          taken = 1'b1;
        end
      end
    end
    for (int c = 0; c < NC; c++) begin
      if (!nf[c]) m_age[c] = m_pr[c] ? 0 : m_age[c] + 1;
      else        m_age[c] = 0;
      m_hd[c] = !nf[c] && (m_age[c] >= HC + 1);
    end
    m_f = nf;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  always @(negedge clk) begin
    if (m_en) begin
      check("model fltrd", 32'(fltrd), 32'(m_f));
      check("model press", 32'(press), 32'(m_pr));
      check("model release", 32'(rel), 32'(m_rl));
      check("model hold", 32'(hold), 32'(m_hd));
    end
  end

  // ---------------- bounce table -----------------------------
  typedef struct {
    logic [NC-1:0] pb;
    int            cyc;
    logic [NC-1:0] exp_f;
    int            exp_pr;
    int            exp_rl;
  } vec_t;

  vec_t tbl [12];

  task automatic idle();
    pb_n = '1;
    tick(12);
  endtask

  initial begin
    tbl[0]  = '{4'b1011, 5, 4'b1111, 0, 0};
    tbl[1]  = '{4'b1111, 1, 4'b1111, 0, 0};
    tbl[2]  = '{4'b1011, 5, 4'b1111, 0, 0};
    tbl[3]  = '{4'b1111, 1, 4'b1111, 0, 0};
    tbl[4]  = '{4'b1011, 9, 4'b1111, 0, 0};
    tbl[5]  = '{4'b1011, 1, 4'b1011, 1, 0};
    tbl[6]  = '{4'b1011, 10, 4'b1011, 0, 0};
    tbl[7]  = '{4'b1111, 3, 4'b1011, 0, 0};
    tbl[8]  = '{4'b1011, 2, 4'b1011, 0, 0};
    tbl[9]  = '{4'b1111, 9, 4'b1011, 0, 0};
    tbl[10] = '{4'b1111, 1, 4'b1111, 0, 1};
    tbl[11] = '{4'b1111, 5, 4'b1111, 0, 0};

    // 1: reset with all buttons held, then release reset
    tick(3);
    m_en = 1'b1;
    check("rst fltrd", 32'(fltrd), 32'hF);
    check("rst press", 32'(press), 32'h0);
    check("rst release", 32'(rel), 32'h0);
    check("rst hold", 32'(hold), 32'h0);
    rst_n = 1'b1;
    tick(9);
    check("s1 fltrd pre", 32'(fltrd), 32'hF);
    tick(1);
    check("s1 fltrd", 32'(fltrd), 32'hE);
    check("s1 press", 32'(press), 32'h1);
    check("s1 nolock fltrd", 32'(fltrd0), 32'h0);
    tick(1);
    check("s1 press once", 32'(press), 32'h0);
    tick(5);
    check("s1 held", 32'(fltrd), 32'hE);
    idle();

    // 2: clean press of ch1, hold, release
    pb_n = 4'b1101;
    tick(9);
    check("s2 press pre", 32'(press), 32'h0);
    tick(1);
    check("s2 press", 32'(press), 32'h2);
    check("s2 fltrd", 32'(fltrd), 32'hD);
    tick(20);
    check("s2 hold pre", 32'(hold), 32'h0);
    tick(1);
    check("s2 hold", 32'(hold), 32'h2);
    tick(9);
    pb_n = 4'b1111;
    tick(9);
    check("s2 rel pre", 32'(rel), 32'h0);
    check("s2 hold kept", 32'(hold), 32'h2);
    tick(1);
    check("s2 rel", 32'(rel), 32'h2);
    check("s2 hold fall", 32'(hold), 32'h0);
    check("s2 fltrd up", 32'(fltrd), 32'hF);
    tick(1);
    check("s2 rel once", 32'(rel), 32'h0);
    idle();

    // 3: bounce table on ch2
    for (int r = 0; r < 12; r++) begin
      int npr, nrl;
      npr = 0; nrl = 0;
      pb_n = tbl[r].pb;
      for (int k = 0; k < tbl[r].cyc; k++) begin
        tick(1);
        npr += $countones(press);
        nrl += $countones(rel);
      end
      check($sformatf("tbl%0d fltrd", r), 32'(fltrd),
            32'(tbl[r].exp_f));
      check($sformatf("tbl%0d press", r), 32'(npr),
            32'(tbl[r].exp_pr));
      check($sformatf("tbl%0d release", r), 32'(nrl),
            32'(tbl[r].exp_rl));
    end
    idle();

    // 4/5: ch0 and ch3 together, with and without lockout
    pb_n = 4'b0110;
    tick(9);
    check("s4 press pre", 32'(press), 32'h0);
    tick(1);
    check("s4 press", 32'(press), 32'h1);
    check("s4 fltrd", 32'(fltrd), 32'hE);
    check("s5 press", 32'(press0), 32'h9);
    check("s5 fltrd", 32'(fltrd0), 32'h6);
    tick(5);
    pb_n = 4'b0111;
    tick(9);
    check("s4 rel pre", 32'(rel), 32'h0);
    check("s4 ch3 waits", 32'(fltrd), 32'hE);
    tick(1);
    check("s4 rel", 32'(rel), 32'h1);
    check("s4 fltrd up", 32'(fltrd), 32'hF);
    check("s4 no press yet", 32'(press), 32'h0);
    check("s5 rel", 32'(rel0), 32'h1);
    check("s5 fltrd", 32'(fltrd0), 32'h7);
    check("s5 hold", 32'(hold0), 32'h0);
    tick(1);
    check("s4 press ch3", 32'(press), 32'h8);
    check("s4 fltrd ch3", 32'(fltrd), 32'h7);
    idle();

    // 6: reset while ch2 in hold, button kept low
    pb_n = 4'b1011;
    tick(31);
    check("s6 hold before", 32'(hold), 32'h4);
    #3 rst_n = 1'b0;
    #1;
    check("s6 hold rst", 32'(hold), 32'h0);
    check("s6 fltrd rst", 32'(fltrd), 32'hF);
    tick(2);
    rst_n = 1'b1;
    tick(9);
    check("s6 press pre", 32'(press), 32'h0);
    tick(1);
    check("s6 press", 32'(press), 32'h4);
    tick(20);
    check("s6 hold pre", 32'(hold), 32'h0);
    tick(1);
    check("s6 hold", 32'(hold), 32'h4);
    idle();

    // random bouncing buttons against the model
    begin
      logic [NC-1:0] lvl;
      int left [NC];
      lvl = '1;
      for (int c = 0; c < NC; c++) left[c] = 0;
      for (int t = 0; t < 3000; t++) begin
        for (int c = 0; c < NC; c++) begin
          if (left[c] == 0) begin
            lvl[c] = 1'($urandom_range(0, 1));
            left[c] = ($urandom_range(0, 3) == 0) ?
                      int'($urandom_range(10, 40)) :
                      int'($urandom_range(1, 9));
          end else begin
            left[c]--;
          end
        end
        pb_n = lvl;
        if (t == 1500) begin
          #2 rst_n = 1'b0;
        end
        if (t == 1503) rst_n = 1'b1;
        tick(1);
      end
    end

    m_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pb_filter_n.md
# pb_filter_n

Parametrised push-button conditioning block, the next generation of the existing `pb_n_filters` stage that sits between the board `pb_n` pins and the button PIO. Per channel it synchronises the raw active-low input, debounces it with a programmable stability window and optionally enforces a cross-talk lockout, so only one button is accepted as pressed at a time. It also emits one-cycle press and release pulses and a long-press hold flag to the processor subsystem or to local logic.

## Interface
- `N_CH`, 4: number of button channels, 1..16.
- `SYNC_STAGES`, 2: synchroniser flops per channel, 2..3.
- `STABLE_CYC`, 500000: consecutive samples (10 ms at 50 MHz) that a new level must hold before it is accepted. Minimum value is 2.
- `HOLD_CYC`, 50000000: cycles a filtered press must persist before `hold` asserts (1 s). A value of 0 disables hold.
- `LOCKOUT`, 1: 1 enables the cross-talk lockout; 0 makes the channels fully independent.

Ports:
- `clkin_50`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `pb_n`  in  N_CH  raw buttons, active-low, asynchronous to `clkin_50`.
- `pb_n_fltrd`  out  N_CH  debounced level, active-low.
- `press_p`  out  N_CH  one-cycle pulse when a press is accepted.
- `release_p`  out  N_CH  one-cycle pulse when a release is accepted.
- `hold`  out  N_CH  level, high while the press has lasted at least `HOLD_CYC` cycles.

## Operation
- All flops reset asynchronously on `rst_n`=0. Reset values: synchroniser flops and `pb_n_fltrd` are all-1 (released); `press_p`, `release_p` and `hold` are 0; all counters are 0.
- **Synchroniser:** each channel passes through a `SYNC_STAGES` flop chain; the last stage is `s[i]`.
- **Debounce counter:** per channel, `cnt` is `$clog2(STABLE_CYC)` bits wide.
  - `s[i]` equals `pb_n_fltrd[i]`: `cnt` clears to 0.
  - `s[i]` differs and `cnt` is less than `STABLE_CYC-1`: `cnt` increments.
  - `s[i]` differs and `cnt` equals `STABLE_CYC-1`: `pb_n_fltrd[i]` toggles and `cnt` clears.
  - Any glitch back to the stable level restarts the window from 0.
- **Lockout** (`LOCKOUT`=1):
  - A channel's released-to-pressed acceptance is inhibited while any other channel's `pb_n_fltrd` is 0. While inhibited, that channel's `cnt` saturates at `STABLE_CYC-1`.
  - If several channels would accept a press in the same cycle, the lowest index wins. The others stay at saturation and accept in the first cycle after every other channel reads released.
  - Release acceptance is never inhibited.
- **Pulses:**
  - `press_p[i]` is 1 exactly in the cycle `pb_n_fltrd[i]` first reads 0.
  - `release_p[i]` is 1 exactly in the cycle `pb_n_fltrd[i]` first reads 1.
- **Hold counter:** per channel, `$clog2(HOLD_CYC+1)` bits wide.
  - Clears while `pb_n_fltrd[i]`=1.
  - Increments while `pb_n_fltrd[i]`=0 and saturates at `HOLD_CYC`.
  - `hold[i]` = (hold counter == `HOLD_CYC`), registered.
  - `hold[i]` falls in the same cycle `release_p[i]` rises.
  - With `HOLD_CYC`=0, `hold` is constantly 0.
- **Reset mid-operation:** all state returns to the released state immediately. A button still held low after reset is accepted as a fresh press after the full latency.

## Timing
- Press latency: `pb_n[i]` falls before edge 0 and stays low. `pb_n_fltrd[i]` and `press_p[i]` change after edge `SYNC_STAGES+STABLE_CYC-1`. Release latency is identical.
- `hold[i]` rises `HOLD_CYC`+1 cycles after `press_p[i]`.
- Outputs are registered with no combinational path from `pb_n`.
- A bounce shorter than `STABLE_CYC` samples produces no output change.

## Structure
- Package `pb_filter_pkg` holds:
  - the default constants `PB_STABLE_CYC_DEF` and `PB_HOLD_CYC_DEF`;
  - a `pb_ch_state_t` struct containing `fltrd`, `cnt` and `hcnt`.
- Sub-module `pb_filter_ch` covers one channel: synchroniser, debounce counter, pulse and hold logic. It has an input `inhibit_press` and a output `want_press`.
- The top level instantiates `N_CH` copies of `pb_filter_ch` with a generate loop. It computes `inhibit_press` from the other channels' `pb_n_fltrd` plus a lowest-index priority mask over `want_press`.

## Test plan
Bench parameters: `N_CH`=4, `STABLE_CYC`=8, `HOLD_CYC`=20, `SYNC_STAGES`=2.

1. Assert reset while `pb_n`=4'b0000 → all outputs at reset values. Release reset → `pb_n_fltrd`=4'b1110 after 9 edges, `press_p`=4'b0001 for exactly one cycle, then ch0 holds the press.
2. Clean press of ch1 → `press_p[1]` at edge 9. Release after 30 cycles → `hold[1]` rises 21 cycles after the press; `hold[1]` falls and `release_p[1]` pulses 9 edges after the release.
3. Bounce ch2 as low 5, high 1, low 5, high 1, then low steady → no change until 8 consecutive low samples. `press_p[2]` occurs exactly once.
4. Press ch3 and ch0 in the same cycle with `LOCKOUT`=1 → only `press_p[0]` at edge 9. Release ch0 → `release_p[0]`, then `press_p[3]` in the following cycle.
5. Same stimulus as scenario 4 with `LOCKOUT`=0 → `press_p`=4'b1001 simultaneously.
6. Assert reset while ch2 `hold`=1 and keep the button held → `hold` and `pb_n_fltrd` reset immediately. After reset release, `press_p[2]` occurs 9 edges later and `hold[2]` 21 cycles after that.
